// File: rtl/mem_dma_arbiter.sv
// Memory DMA arbiter: the CPU owns memory while idle; a READ/HOLD/WRITE engine copies blocks otherwise.
// Optional macro DMA_FILL_EN adds a constant-fill mode (ports fill_mode, fill_value).
module mem_dma_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_read_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [7:0]        len,
`ifdef DMA_FILL_EN
  input  logic              fill_mode,
  input  logic [7:0]        fill_value,
`endif
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_wdata,
  output logic              mem_read_en,
  output logic              cpu_rdy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, HOLD, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_ptr_reg, dst_ptr_reg;
  logic [8:0]        count_reg;
  logic [7:0]        data_reg;
  logic              fill_reg;
  logic              fill_sel;
  logic [7:0]        fill_byte;

`ifdef DMA_FILL_EN
  assign fill_sel  = fill_mode;
  assign fill_byte = fill_value;
`else
  assign fill_sel  = 1'b0;
  assign fill_byte = 8'h00;
`endif

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      count_reg   <= '0;
      data_reg    <= '0;
      fill_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_ptr_reg <= src;
            dst_ptr_reg <= dst;
            // len == 0 means a full 256-byte block
            count_reg   <= (len == 8'd0) ? 9'd256 : {1'b0, len};
            fill_reg    <= fill_sel;
            // fill mode reuses the data register as the constant write value
            if (fill_sel) begin
              data_reg <= fill_byte;
            end
          end
        end
        HOLD: begin
          data_reg <= mem_rdata;
        end
        WRITE: begin
          src_ptr_reg <= src_ptr_reg + 1'b1;
          dst_ptr_reg <= dst_ptr_reg + 1'b1;
          count_reg   <= count_reg - 9'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_address = cpu_address;
    mem_wdata   = cpu_wdata;
    mem_read_en = cpu_read_en;
    cpu_rdy     = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = fill_sel ? WRITE : READ;
        end
      end
      READ, HOLD: begin
        mem_address = src_ptr_reg;
        mem_wdata   = data_reg;
        mem_read_en = 1'b1;
        cpu_rdy     = 1'b0;
        busy        = 1'b1;
        state_next  = (state_reg == READ) ? HOLD : WRITE;
      end
      WRITE: begin
        mem_address = dst_ptr_reg;
        mem_wdata   = data_reg;
        mem_read_en = 1'b0;
        cpu_rdy     = 1'b0;
        busy        = 1'b1;
        if (count_reg == 9'd1) begin
          state_next = DONE;
        end else begin
          state_next = fill_reg ? WRITE : READ;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma_arbiter.sv
// Scoreboard bench for mem_dma_arbiter: a byte-level reference model predicts every DMA write and
// each done pulse; a monitor checks them as the DUT produces them. Fill tests need DMA_FILL_EN.
module tb_mem_dma_arbiter;
  logic        ph1 = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_read_en;
  logic        start;
  logic [15:0] src, dst;
  logic [7:0]  len;
`ifdef DMA_FILL_EN
  logic        fill_mode;
  logic [7:0]  fill_value;
`endif
  logic [7:0]  mem_rdata;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_read_en;
  logic        cpu_rdy, busy, done;

  mem_dma_arbiter #(.ADDR_W(16)) dut (
    .ph1(ph1), .reset(reset),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_read_en(cpu_read_en),
    .start(start), .src(src), .dst(dst), .len(len),
`ifdef DMA_FILL_EN
    .fill_mode(fill_mode), .fill_value(fill_value),
`endif
    .mem_rdata(mem_rdata), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read_en(mem_read_en), .cpu_rdy(cpu_rdy), .busy(busy), .done(done)
  );

  initial forever #5 ph1 = ~ph1;

  // system memory: registered read, write when read_en is low
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  always @(posedge ph1) begin
    mem_rdata <= mem[mem_address];
    if (!mem_read_en) mem[mem_address] = mem_wdata;
  end

  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int busy_cycles; int reads; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];

  int compared = 0;
  int mismatched = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int busy_cnt = 0;
  int read_cnt = 0;
  bit noise_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Reference: byte i of a transfer goes to dst+i, taken from src+i (ascending, so overlaps propagate).
  // Only the first `keep` bytes are predicted; a full transfer also predicts its done pulse.
  task automatic plan(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                      input bit fill, input logic [7:0] fv, input int keep);
    int n;
    logic [15:0] sa, da;
    logic [7:0] b;
    wr_t w;
    done_t dn;
    n = (l == 8'd0) ? 256 : int'(l);
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      b = fill ? fv : ref_mem[sa];
      if (i < keep) begin
        ref_mem[da] = b;
        w.addr = da;
        w.data = b;
        wr_q.push_back(w);
      end
    end
    if (keep >= n) begin
      dn.busy_cycles = fill ? n : 3 * n;
      dn.reads = fill ? 0 : 2 * n;
      done_q.push_back(dn);
    end
  endtask

  // monitor
  always @(negedge ph1) begin
    wr_t w;
    done_t dn;
    if (reset) begin
      busy_cnt = 0;
      read_cnt = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cpu_rdy", cpu_rdy, 1);
      chk("rst_mirror_addr", mem_address, cpu_address);
    end else if (busy) begin
      busy_cnt++;
      if (mem_read_en) read_cnt++;
      chk("busy_cpu_rdy", cpu_rdy, 0);
      if (!mem_read_en) begin
        wr_seen++;
        if (wr_q.size() == 0) begin
          chk("unexpected_write_addr", mem_address, 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          chk("write_addr", mem_address, w.addr);
          chk("write_data", mem_wdata, w.data);
        end
      end
    end else begin
      chk("idle_cpu_rdy", cpu_rdy, 1);
      chk("mirror_addr", mem_address, cpu_address);
      chk("mirror_wdata", mem_wdata, cpu_wdata);
      chk("mirror_rd", mem_read_en, cpu_read_en);
      if (!cpu_read_en) ref_mem[cpu_address] = cpu_wdata;
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          dn = done_q.pop_front();
          chk("busy_cycles", busy_cnt, dn.busy_cycles);
          chk("read_strobes", read_cnt, dn.reads);
        end
        busy_cnt = 0;
        read_cnt = 0;
      end
    end
  end

  // CPU bus noise while the engine owns memory
  always @(posedge ph1) begin
    #1;
    if (noise_on) begin
      cpu_address = 16'($urandom);
      cpu_wdata   = 8'($urandom);
      cpu_read_en = 1'($urandom);
    end
  end

  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                          input bit fill, input logic [7:0] fv, input bit restart);
    int target, t, n;
    n = (l == 8'd0) ? 256 : int'(l);
    @(posedge ph1); #1;
    noise_on = 1'b0;
    cpu_read_en = 1'b1;
    src = s; dst = d; len = l; start = 1'b1;
`ifdef DMA_FILL_EN
    fill_mode = fill; fill_value = fv;
`endif
    plan(s, d, l, fill, fv, 1000);
    target = done_seen + 1;
    @(posedge ph1); #1;
    start = 1'b0;
    src = 16'($urandom); dst = 16'($urandom); len = 8'($urandom);
`ifdef DMA_FILL_EN
    fill_mode = ~fill;
`endif
    noise_on = 1'b1;
    t = 0;
    while (done_seen < target && t < 3000) begin
      @(posedge ph1); #1;
      t++;
      if (restart && t == 4) begin
        start = 1'b1; src = s + 16'h0100; dst = d + 16'h0040; len = 8'd7;
        @(posedge ph1); #1;
        start = 1'b0;
        t++;
      end
    end
    if (done_seen < target) chk("done_timeout", t, 0);
    noise_on = 1'b0;
    cpu_read_en = 1'b1;
    @(posedge ph1); #1;
    for (int i = 0; i < n; i++) chk("dst_byte", mem[d + 16'(i)], ref_mem[d + 16'(i)]);
    $display("xfer src=%h dst=%h len=%0d fill=%0d restart=%0d", s, d, n, fill, restart);
  endtask

  initial begin
    int base, t, base_done;
    logic [15:0] rs, rd;
    logic [7:0] rl;
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    cpu_address = 16'h0123; cpu_wdata = 8'h45; cpu_read_en = 1'b1;
`ifdef DMA_FILL_EN
    fill_mode = 1'b0; fill_value = 8'h00;
`endif
    for (int i = 0; i < 65536; i++) poke(16'(i), 8'($urandom));
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_cpu_rdy", cpu_rdy, 1);
    chk("reset_done", done, 0);
    chk("reset_mirror", mem_address, 16'h0123);
    @(posedge ph1); #1;
    reset = 1'b0;

    // CPU write while idle
    cpu_address = 16'h1234; cpu_wdata = 8'h5A; cpu_read_en = 1'b0;
    @(posedge ph1); #1;
    cpu_read_en = 1'b1;
    @(posedge ph1); #1;
    chk("cpu_write", mem[16'h1234], 8'h5A);
    $display("cpu write 1234=5A");

    // basic 4-byte copy
    poke(16'h0200, 8'h11); poke(16'h0201, 8'h22); poke(16'h0202, 8'h33); poke(16'h0203, 8'h44);
    run_xfer(16'h0200, 16'h0300, 8'd4, 1'b0, 8'h00, 1'b0);
    chk("copy4_b0", mem[16'h0300], 8'h11);
    chk("copy4_b1", mem[16'h0301], 8'h22);
    chk("copy4_b2", mem[16'h0302], 8'h33);
    chk("copy4_b3", mem[16'h0303], 8'h44);

    // len=0 is 256 bytes
    run_xfer(16'h1000, 16'h2000, 8'd0, 1'b0, 8'h00, 1'b0);
    chk("len0_last", mem[16'h20FF], mem[16'h10FF]);

    // source pointer wraps
    poke(16'hFFFE, 8'h61); poke(16'hFFFF, 8'h62); poke(16'h0000, 8'h63);
    run_xfer(16'hFFFE, 16'h4000, 8'd3, 1'b0, 8'h00, 1'b0);
    chk("wrap_b0", mem[16'h4000], 8'h61);
    chk("wrap_b1", mem[16'h4001], 8'h62);
    chk("wrap_b2", mem[16'h4002], 8'h63);

    // start while busy is ignored
    run_xfer(16'h0600, 16'h0700, 8'd6, 1'b0, 8'h00, 1'b1);

`ifdef DMA_FILL_EN
    run_xfer(16'h3333, 16'h0500, 8'd8, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) chk("fill_byte", mem[16'h0500 + 16'(i)], 8'hA5);
`endif

    // reset mid-copy after two bytes written
    for (int i = 0; i < 4; i++) begin
      poke(16'h0800 + 16'(i), 8'h70 + 8'(i));
      poke(16'h0900 + 16'(i), 8'hEE);
    end
    @(posedge ph1); #1;
    src = 16'h0800; dst = 16'h0900; len = 8'd4; start = 1'b1;
`ifdef DMA_FILL_EN
    fill_mode = 1'b0;
`endif
    plan(16'h0800, 16'h0900, 8'd4, 1'b0, 8'h00, 2);
    base = wr_seen;
    @(posedge ph1); #1;
    start = 1'b0;
    t = 0;
    while (wr_seen < base + 2 && t < 100) begin
      @(negedge ph1);
      t++;
    end
    if (wr_seen < base + 2) chk("reset_wait_timeout", t, 0);
    @(posedge ph1); #1;
    reset = 1'b1;
    base_done = done_seen;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_rdy", cpu_rdy, 1);
    chk("midrst_done", done, 0);
    @(posedge ph1); #1;
    reset = 1'b0;
    repeat (20) @(posedge ph1);
    #1;
    chk("midrst_no_done", done_seen, base_done);
    chk("midrst_b0", mem[16'h0900], 8'h70);
    chk("midrst_b1", mem[16'h0901], 8'h71);
    chk("midrst_b2", mem[16'h0902], 8'hEE);
    chk("midrst_b3", mem[16'h0903], 8'hEE);
    $display("reset mid-copy src=0800 dst=0900 len=4");

    // random copies, some overlapping
    for (int k = 0; k < 12; k++) begin
      rs = 16'($urandom);
      rd = (k % 3 == 0) ? rs + 16'($urandom_range(1, 6)) : 16'($urandom);
      rl = 8'($urandom_range(0, 24));
      run_xfer(rs, rd, rl, 1'b0, 8'h00, 1'($urandom));
    end

    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
